// File: rtl/ntt_agu_pkg.sv
// Shared constants and types for the NTT address generation unit.
// AGU_ITER_OFFSET_EN widens the memory address by the iteration number.
package ntt_agu_pkg;

    localparam int D_WIDTH  = 8;
    localparam int R_WIDTH  = 2;
    localparam int MA_WIDTH = D_WIDTH - R_WIDTH;
    localparam int K        = 2;
    localparam int LATENCY  = 6;
    localparam int DEGREE   = 2 ** D_WIDTH;
    localparam int RADIX    = 2 ** R_WIDTH;
    localparam int N_DIGITS = D_WIDTH / R_WIDTH;
    localparam int IT_W     = (K > 1) ? $clog2(K) : 1;
    // One extra state beyond K-1 marks the finished run.
    localparam int IT_CNT_W = $clog2(K + 1);

`ifdef AGU_ITER_OFFSET_EN
    localparam int MA_OUT_W = MA_WIDTH + IT_W;
`else
    localparam int MA_OUT_W = MA_WIDTH;
`endif

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [R_WIDTH-1:0]  bn;
        logic [MA_OUT_W-1:0] ma;
    } pipe_t;

endpackage

// File: rtl/ntt_agu_if.sv
// Output bus of the AGU toward the bank crossbar and address ports.
// The MA_idx width follows AGU_ITER_OFFSET_EN through MA_OUT_W.
interface ntt_agu_if;
    import ntt_agu_pkg::*;

    logic                AGU_enable;
    logic [MA_OUT_W-1:0] MA_idx;
    logic [R_WIDTH-1:0]  BN_idx;
    logic                BN_MA_out_en;
    logic                AGU_done_out;

    modport master (
        input  AGU_enable,
        output MA_idx,
        output BN_idx,
        output BN_MA_out_en,
        output AGU_done_out
    );

    modport slave (
        output AGU_enable,
        input  MA_idx,
        input  BN_idx,
        input  BN_MA_out_en,
        input  AGU_done_out
    );

endinterface

// File: rtl/ntt_agu_bank_map.sv
// Conflict-free bank selection: sum of the radix digits of j, modulo RADIX.
module ntt_agu_bank_map
    import ntt_agu_pkg::*;
(
    input  logic [D_WIDTH-1:0] j_idx,
    output logic [R_WIDTH-1:0] bn_idx
);

    logic [R_WIDTH-1:0] digit [0:N_DIGITS-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit[gi] = j_idx[gi*R_WIDTH +: R_WIDTH];
        end
    endgenerate

    // R_WIDTH-bit accumulation wraps naturally, giving the mod-RADIX result.
    always_comb begin
        bn_idx = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            bn_idx = bn_idx + digit[d];
        end
    end

endmodule

// File: rtl/ntt_agu.sv
// NTT address generation unit: index counter, bank mapping, fixed-latency delay pipe, done flag.
// AGU_ITER_OFFSET_EN places each polynomial in its own address region.
module ntt_agu
    import ntt_agu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ntt_agu_if.master agu
);

    localparam logic [IT_CNT_W-1:0] IT_END  = IT_CNT_W'(K);
    localparam logic [IT_CNT_W-1:0] IT_LAST = IT_CNT_W'(K - 1);
    localparam logic [D_WIDTH-1:0]  J_LAST  = D_WIDTH'(DEGREE - 1);

    logic [D_WIDTH-1:0]  j_q, j_d;
    logic [IT_CNT_W-1:0] it_q, it_d;
    logic                inject;
    logic [R_WIDTH-1:0]  bn_w;
    logic [MA_OUT_W-1:0] ma_w;
    pipe_t               stage_in;
    pipe_t               pipe_q [0:LATENCY-2];
    pipe_t               pipe_d [0:LATENCY-2];
    pipe_t               out_q, out_d;
    logic                done_q, done_d;

    ntt_agu_bank_map u_bank_map (
        .j_idx  (j_q),
        .bn_idx (bn_w)
    );

    // Once it reaches K the counter freezes and enable is ignored until reset.
    always_comb begin
        inject = agu.AGU_enable && (it_q != IT_END);
        j_d    = j_q;
        it_d   = it_q;
        if (inject) begin
            j_d = j_q + D_WIDTH'(1);
            if (j_q == J_LAST) begin
                it_d = it_q + IT_CNT_W'(1);
            end
        end
    end

    always_comb begin
`ifdef AGU_ITER_OFFSET_EN
        ma_w = {it_q[IT_W-1:0], j_q[D_WIDTH-1:R_WIDTH]};
`else
        ma_w = j_q[D_WIDTH-1:R_WIDTH];
`endif
        stage_in       = '0;
        stage_in.valid = inject;
        stage_in.last  = inject && (j_q == J_LAST) && (it_q == IT_LAST);
        stage_in.bn    = bn_w;
        stage_in.ma    = ma_w;
    end

    assign pipe_d[0] = stage_in;

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY - 1; gi++) begin : g_pipe
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    endgenerate

    // Output stage only reloads data on a valid entry so bubbles hold the last pair.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        out_d.last  = 1'b0;
        if (pipe_q[LATENCY-2].valid) begin
            out_d = pipe_q[LATENCY-2];
        end
        done_d = done_q | (out_q.valid & out_q.last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q    <= '0;
            it_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            j_q    <= j_d;
            it_q   <= it_d;
            out_q  <= out_d;
            done_q <= done_d;
            for (int i = 0; i < LATENCY - 1; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign agu.MA_idx       = out_q.ma;
    assign agu.BN_idx       = out_q.bn;
    assign agu.BN_MA_out_en = out_q.valid;
    assign agu.AGU_done_out = done_q;

endmodule

// File: tb/tb_ntt_agu.sv
// Self-checking bench for ntt_agu: table vectors, enable-pattern streams and a mid-run reset,
// all checked against a digit-sum reference model. AGU_ITER_OFFSET_EN selects offset addressing.
module tb_ntt_agu;
    import ntt_agu_pkg::*;

    localparam int TOTAL = DEGREE * K;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ntt_agu_if agu_if ();

    ntt_agu dut (
        .clk (clk),
        .rst (rst),
        .agu (agu_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cap_bn [TOTAL];
    int cap_ma [TOTAL];
    int hist_v [0:1023];
    int hist_n [0:1023];

    typedef struct {
        int n;
        int bn;
        int ma;
    } vec_t;
    vec_t vecs [8];

    function automatic int model_bn(input int n);
        int j = n % DEGREE;
        int s = 0;
        for (int d = 0; d < N_DIGITS; d++) s += (j / (RADIX ** d)) % RADIX;
        return s % RADIX;
    endfunction

    function automatic int model_ma(input int n);
        int m = (n % DEGREE) / RADIX;
`ifdef AGU_ITER_OFFSET_EN
        m += (n / DEGREE) * (DEGREE / RADIX);
`endif
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, int'(agu_if.BN_MA_out_en), 0);
        chk({tag, "_done"},  int'(agu_if.AGU_done_out), 0);
        chk({tag, "_ma"},    int'(agu_if.MA_idx), 0);
        chk({tag, "_bn"},    int'(agu_if.BN_idx), 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        agu_if.AGU_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;
    endtask

    // mode 0: enable always high; 1: enable low on edges 101..103; 2: random enable.
    task automatic run_stream(input int mode, input int ncyc, output int first_valid, output int bubbles);
        int  cnt       = 0;
        int  last_edge = 0;
        int  exp_bn    = 0;
        int  exp_ma    = 0;
        int  n_valid   = 0;
        int  ev, n;
        bit  en;
        first_valid = -1;
        bubbles     = 0;
        for (int k = 1; k <= ncyc; k++) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = !(k >= 101 && k <= 103);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            agu_if.AGU_enable = en;
            @(posedge clk);
            hist_v[k] = (en && cnt < TOTAL) ? 1 : 0;
            hist_n[k] = cnt;
            if (hist_v[k] != 0) cnt++;
            @(negedge clk);
            ev = (k >= LATENCY) ? hist_v[k-LATENCY+1] : 0;
            n  = (k >= LATENCY) ? hist_n[k-LATENCY+1] : 0;
            if (ev != 0) begin
                exp_bn = model_bn(n);
                exp_ma = model_ma(n);
                if (n == TOTAL - 1) last_edge = k;
                cap_bn[n] = int'(agu_if.BN_idx);
                cap_ma[n] = int'(agu_if.MA_idx);
            end
            chk($sformatf("m%0d_valid@%0d", mode, k), int'(agu_if.BN_MA_out_en), ev);
            chk($sformatf("m%0d_bn@%0d", mode, k), int'(agu_if.BN_idx), exp_bn);
            chk($sformatf("m%0d_ma@%0d", mode, k), int'(agu_if.MA_idx), exp_ma);
            chk($sformatf("m%0d_done@%0d", mode, k), int'(agu_if.AGU_done_out),
                (last_edge != 0 && k > last_edge) ? 1 : 0);
            if (agu_if.BN_MA_out_en) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
            end else if (first_valid > 0 && last_edge == 0) begin
                bubbles++;
            end
        end
        chk($sformatf("m%0d_pair_count", mode), n_valid, TOTAL);
        $display("stream mode=%0d cycles=%0d first_valid=%0d bubbles=%0d pairs=%0d",
                 mode, ncyc, first_valid, bubbles, n_valid);
    endtask

    task automatic check_vecs(input string tag, input int nvec);
        for (int i = 0; i < nvec; i++) begin
            chk($sformatf("%s_bn_pair%0d", tag, vecs[i].n), cap_bn[vecs[i].n], vecs[i].bn);
            chk($sformatf("%s_ma_pair%0d", tag, vecs[i].n), cap_ma[vecs[i].n], vecs[i].ma);
            $display("vec %s pair=%0d bn=%0d ma=%0d want bn=%0d ma=%0d", tag, vecs[i].n,
                     cap_bn[vecs[i].n], cap_ma[vecs[i].n], vecs[i].bn, vecs[i].ma);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv, bub;
        vecs[0] = '{n: 0,   bn: 0, ma: 0};
        vecs[1] = '{n: 1,   bn: 1, ma: 0};
        vecs[2] = '{n: 4,   bn: 1, ma: 1};
        vecs[3] = '{n: 5,   bn: 2, ma: 1};
        vecs[4] = '{n: 27,  bn: 2, ma: 6};
        vecs[5] = '{n: 255, bn: 0, ma: 63};
`ifdef AGU_ITER_OFFSET_EN
        vecs[6] = '{n: 256, bn: 0, ma: 64};
        vecs[7] = '{n: 511, bn: 0, ma: 127};
`else
        vecs[6] = '{n: 256, bn: 0, ma: 0};
        vecs[7] = '{n: 511, bn: 0, ma: 63};
`endif
        agu_if.AGU_enable = 1'b0;

        // Continuous enable: latency, full stream, iteration wrap, done and quiet tail.
        do_reset();
        run_stream(0, 560, fv, bub);
        chk("first_valid_edge", fv, 6);
        chk("continuous_bubbles", bub, 0);
        check_vecs("cont", 8);

        // Three-cycle enable drop mid-stream.
        do_reset();
        run_stream(1, 600, fv, bub);
        chk("drop_bubbles", bub, 3);
        chk("drop_first_valid_edge", fv, 6);

        // Asynchronous reset mid-run, checked before any further clock edge.
        do_reset();
        agu_if.AGU_enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("pre_rst_valid", int'(agu_if.BN_MA_out_en), 1);
        rst = 1'b1;
        #1;
        chk_cleared("async_rst");
        $display("async reset applied mid-run");
        do_reset();
        run_stream(0, 560, fv, bub);
        chk("rerun_first_valid_edge", fv, 6);
        check_vecs("rerun", 4);

        // Random enable pattern.
        do_reset();
        run_stream(2, 1000, fv, bub);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
